// File: rtl/split_odd_even_gbx.sv
// Receive-side odd/even de-interleaver with 2:1 gearbox: one WIDTH-bit word in,
// two WIDTH/2-bit halves out on consecutive beats, behind a one-word holding register.
module split_odd_even_gbx #(
   parameter int unsigned WIDTH = 20,
   parameter int unsigned CNT_W = 16
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic [WIDTH-1:0]   din,
   input  logic               din_valid,
   output logic               din_ready,
   input  logic               swap,
   output logic [WIDTH/2-1:0] dout,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic               dout_lane,
   output logic               dout_last,
   output logic [CNT_W-1:0]   word_cnt
);

   localparam int unsigned HALF_W = WIDTH / 2;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [1:0]          sync_q;
   logic                run;
   logic                accept;
   logic [HALF_W-1:0]   even_c;
   logic [HALF_W-1:0]   odd_c;
   logic [HALF_W-1:0]   even_q;
   logic [HALF_W-1:0]   odd_q;
   logic                swap_q;

   // Split the interleaved word into even-indexed and odd-indexed bits.
   for (genvar i = 0; i < HALF_W; i++) begin : g_split
      assign even_c[i] = din[2*i];
      assign odd_c[i]  = din[2*i+1];
   end

   // Two-flop reset de-assertion synchronizer gating input acceptance.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], 1'b1};
      end
   end

   assign run        = sync_q[1];
   assign din_ready  = run & ((state == EMPTY) | ((state == SECOND) & dout_ready));
   assign dout_valid = (state != EMPTY);
   assign accept     = din_valid & din_ready;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Holding register and accepted-word counter.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         even_q   <= '0;
         odd_q    <= '0;
         swap_q   <= 1'b0;
         word_cnt <= '0;
      end else if (accept) begin
         even_q   <= even_c;
         odd_q    <= odd_c;
         swap_q   <= swap;
         word_cnt <= word_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      dout      = '0;
      dout_lane = 1'b0;
      dout_last = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) state_nxt = FIRST;
         end
         FIRST: begin
            dout      = swap_q ? odd_q : even_q;
            dout_lane = swap_q;
            if (dout_ready) state_nxt = SECOND;
         end
         SECOND: begin
            dout      = swap_q ? even_q : odd_q;
            dout_lane = ~swap_q;
            dout_last = 1'b1;
            // A word arriving on the final handshake reloads with no bubble.
            if (dout_ready) state_nxt = accept ? FIRST : EMPTY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

endmodule

// File: doc/split_odd_even_gbx.md
# split_odd_even_gbx

Receive-side de-interleaver and 2:1 gearbox for the SL3 lane datapath, the inverse of the odd/even bit mixer on the transmit side. It accepts a WIDTH-bit interleaved word over a valid/ready handshake, separates even-indexed bits from odd-indexed bits, and emits the two WIDTH/2-bit halves on consecutive output beats. A one-word holding register decouples input and output back-pressure. The block sits between the lane word aligner and the per-half descramblers.

## Interface
- WIDTH, 20: input word width; must be even and at least 2. Output width is WIDTH/2.
- CNT_W, 16: width of the accepted-word counter.

- clk  in  1  single clock for all logic.
- arst_n  in  1  asynchronous, active-low reset.
- din  in  WIDTH  interleaved input word.
- din_valid  in  1  din is valid.
- din_ready  out  1  block accepts din at this edge; combinational from dout_ready.
- swap  in  1  sampled with each accepted word; 1 = odd half is emitted first.
- dout  out  WIDTH/2  current output half.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  downstream accepts dout at this edge.
- dout_lane  out  1  0 = dout holds even bits, 1 = dout holds odd bits.
- dout_last  out  1  dout is the second half of its word.
- word_cnt  out  CNT_W  count of accepted input words; wraps modulo 2^CNT_W.

## Operation
- De-interleave, for i in 0..WIDTH/2-1:
  - even half E[i] = din[2i]
  - odd half O[i] = din[2i+1]
- Mixing {O,E} with the transmit mixer reproduces din exactly.
- On acceptance (din_valid & din_ready at an edge), register E, O, and the sampled swap into the holding register.
- FSM states and transitions:
  - EMPTY → FIRST on acceptance.
  - FIRST → SECOND on output handshake (dout_valid & dout_ready).
  - SECOND → EMPTY on output handshake with no new acceptance.
  - SECOND → FIRST on output handshake with a simultaneous acceptance. The new word loads in the same edge.
- din_ready = (state==EMPTY) | (state==SECOND & dout_ready). It is never asserted in FIRST.
- dout_valid = (state != EMPTY).
- In FIRST:
  - dout = swap_q ? O : E
  - dout_lane = swap_q
  - dout_last = 0
- In SECOND:
  - dout = swap_q ? E : O
  - dout_lane = ~swap_q
  - dout_last = 1
- dout, dout_lane and dout_last hold stable while dout_valid=1 and dout_ready=0.
- word_cnt increments by 1 on each acceptance and wraps from 2^CNT_W-1 to 0.
- din is ignored when din_valid=0. din_valid falling without acceptance has no effect.
- Reset values (async assertion of arst_n=0):
  - state = EMPTY
  - dout_valid = 0
  - din_ready = 1 once reset is released; held at 0 while arst_n=0
  - dout = 0, dout_lane = 0, dout_last = 0
  - word_cnt = 0
  - swap_q = 0
- Reset mid-word: the held word is discarded and its second half is never emitted. word_cnt is not decremented; it is cleared to 0.

## Timing
- Latency: a word accepted at edge T presents its first half from T+1 (dout_valid=1 after T). With dout_ready=1, the second half is presented from T+2.
- Throughput: one input word per 2 cycles at sustained rate, with dout_valid continuously 1 and no bubble between words when din_valid and dout_ready are both held high.
- No combinational path from din or din_valid to any output. The only combinational path is dout_ready → din_ready.
- Back-pressure: with dout_ready=0, at most one word is held and din_ready=0 after the first acceptance.
- Reset release is synchronous to clk through a two-flop de-assertion synchronizer. The first acceptance can occur at the third rising edge after arst_n rises.

## Test plan
- WIDTH=8, swap=0, din=0xB4 with dout_ready=1 → dout=0x6 (lane 0, last 0), then 0xC (lane 1, last 1); word_cnt=1.
- Same word with swap=1 → dout=0xC (lane 1, last 0), then 0x6 (lane 0, last 1).
- Stream 0xB4, 0xFF, 0x00 with din_valid and dout_ready held 1 → dout sequence 6, C, F, F, 0, 0 on consecutive cycles; din_ready pattern 1,0,1,0,1; dout_valid never drops.
- Accept 0xB4, hold dout_ready=0 for 5 cycles → dout stays 0x6 and din_ready stays 0. Release dout_ready → 0x6 then 0xC; din_ready=1 in the SECOND cycle.
- Assert arst_n=0 while in SECOND → dout_valid=0, word_cnt=0, dout=0 immediately. After release, the pending 0xC half is never emitted.
- Random WIDTH=20 words with random din_valid/dout_ready; the scoreboard re-mixes each half pair and compares against din (zero mismatches). Preload CNT_W=4 past 15 acceptances → word_cnt wraps to 0.
